// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA pixel-fetch block:
//   - 640x480 timing extents and totals (800x525 with blanking)
//   - 256x256 image window placement (centred horizontally, offset vertically)
//   - border colour, pixel-class tag, bank-flip FSM state encoding
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam logic [9:0] IMG_W    = 10'd256;
  localparam logic [9:0] IMG_H    = 10'd256;
  localparam logic [9:0] IMG_X0   = 10'd192;
  localparam logic [9:0] IMG_Y0   = 10'd112;

  // {r, g, b} shown in the active area outside the image window
  localparam logic [23:0] BORDER_RGB = 24'h000040;

  // Pipeline depth from hs/vs input to registered RGB output
  localparam int SYNC_DEPTH = 3;

  typedef enum logic [1:0] {
    PIX_BLACK  = 2'd0,
    PIX_BORDER = 2'd1,
    PIX_IMAGE  = 2'd2
  } pix_class_e;

  typedef enum logic [1:0] {
    BANK_IDLE    = 2'd0,
    BANK_PENDING = 2'd1,
    BANK_ACKED   = 2'd2
  } bank_state_e;

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch_if
// Framebuffer read bus between the pixel fetcher (master) and memory (slave).
//   mem_addr [16:0] : {bank_sel, y[7:0], x[7:0]}
//   mem_rd          : address valid for an in-image pixel
//   mem_data [7:0]  : grayscale pixel, returned one cycle after mem_addr/mem_rd
// ----------------------------------------------------------------------------
interface vga_pixel_fetch_if;

  logic [16:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );

endinterface

// File: rtl/sync_delay.sv
// ----------------------------------------------------------------------------
// sync_delay
// DEPTH-stage shift register for an active-low sync, reset to 1 (inactive).
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   d_i   : sync in
//   q_o   : sync delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module sync_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Next shift-register contents: new sample enters at bit 0
  always_comb begin
    shift_d    = shift_q;
    shift_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      shift_d[i] = shift_q[i-1];
    end
  end

  // Shift register state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= {DEPTH{1'b1}};
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch
// Fetches a 256x256 grayscale image from a double-buffered framebuffer and
// produces 640x480 VGA RGB with a blue border and black blanking.
//   clk_25, rst            : pixel clock, synchronous active-high reset
//   hs, vs                 : pixel/line counters from the timing generator
//   hsync_in, vsync_in     : active-low syncs aligned with hs/vs
//   mem                    : framebuffer read bus (master side)
//   swap_req / swap_ack    : bank-flip level request / one-cycle acknowledge
//   bank_sel               : bank currently displayed
//   frame_start            : one-cycle pulse the cycle after hs==0,vs==0
//   vga_r/g/b, vga_h/vsync : outputs, 3 cycles behind hs/vs
// Pipeline: S1 address+class, S2 memory data returns, S3 RGB register.
// ----------------------------------------------------------------------------
module vga_pixel_fetch
  import vga_pkg::*;
(
  input  logic        clk_25,
  input  logic        rst,
  input  logic [9:0]  hs,
  input  logic [9:0]  vs,
  input  logic        hsync_in,
  input  logic        vsync_in,
  vga_pixel_fetch_if.master mem,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        bank_sel,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  logic [9:0]  x_off_s;
  logic [9:0]  y_off_s;
  logic        in_img_s;
  logic        active_s;
  logic        swap_point_s;

  logic [16:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q,   mem_rd_d;
  pix_class_e  tag1_q,     tag1_d;
  pix_class_e  tag2_q;
  logic [23:0] rgb_q,      rgb_d;
  logic        frame_start_q, frame_start_d;

  bank_state_e state_q, state_d;
  logic        bank_q,  bank_d;
  logic        ack_q,   ack_d;

  // Unsigned 10-bit offsets: coordinates left/above the window wrap to large
  // values, so a single "< size" compare covers both window edges.
  assign x_off_s      = hs - IMG_X0;
  assign y_off_s      = vs - IMG_Y0;
  assign in_img_s     = (x_off_s < IMG_W) && (y_off_s < IMG_H);
  assign active_s     = (hs < H_ACTIVE) && (vs < V_ACTIVE);
  assign swap_point_s = (hs == 10'd0) && (vs == V_ACTIVE);

  // Stage 1: framebuffer address, read strobe, pixel class, frame-start decode
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = 1'b0;
    tag1_d        = PIX_BLACK;
    frame_start_d = (hs == 10'd0) && (vs == 10'd0);
    if (in_img_s) begin
      mem_addr_d = {bank_q, y_off_s[7:0], x_off_s[7:0]};
      mem_rd_d   = 1'b1;
      tag1_d     = PIX_IMAGE;
    end else if (active_s) begin
      tag1_d = PIX_BORDER;
    end else begin
      tag1_d = PIX_BLACK;
    end
  end

  // Stage 3: colour selection using the class tag aligned with mem_data
  always_comb begin
    rgb_d = 24'h000000;
    case (tag2_q)
      PIX_IMAGE:  rgb_d = {mem.mem_data, mem.mem_data, mem.mem_data};
      PIX_BORDER: rgb_d = BORDER_RGB;
      PIX_BLACK:  rgb_d = 24'h000000;
      default:    rgb_d = 24'h000000;
    endcase
  end

  // Bank-flip FSM: flip only at the first blanking line so the displayed
  // bank never changes inside an active frame. swap_ack and bank_sel are
  // registered and become visible the cycle after the flip point.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    case (state_q)
      BANK_IDLE: begin
        if (swap_req) begin
          state_d = BANK_PENDING;
        end else begin
          state_d = BANK_IDLE;
        end
      end
      BANK_PENDING: begin
        if (swap_point_s) begin
          state_d = BANK_ACKED;
          bank_d  = ~bank_q;
          ack_d   = 1'b1;
        end else begin
          state_d = BANK_PENDING;
        end
      end
      BANK_ACKED: begin
        // Wait for the requester to drop the level before re-arming
        if (!swap_req) begin
          state_d = BANK_IDLE;
        end else begin
          state_d = BANK_ACKED;
        end
      end
      default: begin
        state_d = BANK_IDLE;
      end
    endcase
  end

  // Pipeline and FSM registers
  always_ff @(posedge clk_25) begin
    if (rst) begin
      mem_addr_q    <= 17'd0;
      mem_rd_q      <= 1'b0;
      tag1_q        <= PIX_BLACK;
      tag2_q        <= PIX_BLACK;
      rgb_q         <= 24'h000000;
      frame_start_q <= 1'b0;
      state_q       <= BANK_IDLE;
      bank_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag1_q;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
      bank_q        <= bank_d;
      ack_q         <= ack_d;
    end
  end

  sync_delay #(.DEPTH(SYNC_DEPTH)) u_hsync_delay (
    .clk_i (clk_25),
    .rst_i (rst),
    .d_i   (hsync_in),
    .q_o   (vga_hsync)
  );

  sync_delay #(.DEPTH(SYNC_DEPTH)) u_vsync_delay (
    .clk_i (clk_25),
    .rst_i (rst),
    .d_i   (vsync_in),
    .q_o   (vga_vsync)
  );

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign swap_ack     = ack_q;
  assign bank_sel     = bank_q;
  assign frame_start  = frame_start_q;
  assign vga_r        = rgb_q[23:16];
  assign vga_g        = rgb_q[15:8];
  assign vga_b        = rgb_q[7:0];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// tb_vga_pixel_fetch
// Directed bench for vga_pixel_fetch. The framebuffer model returns
// 0x7F ^ x ^ y ^ (bank ? 0x80 : 0x00) one cycle after a read; expected
// pixel values below are hand-computed from that rule.
// ----------------------------------------------------------------------------
module tb_vga_pixel_fetch;

  logic       clk_25;
  logic       rst;
  logic [9:0] hs;
  logic [9:0] vs;
  logic       hsync_in;
  logic       vsync_in;
  logic       swap_req;
  logic       swap_ack;
  logic       bank_sel;
  logic       frame_start;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;

  int n_pass  = 0;
  int n_total = 0;

  vga_pixel_fetch_if mem_bus ();

  vga_pixel_fetch dut (
    .clk_25      (clk_25),
    .rst         (rst),
    .hs          (hs),
    .vs          (vs),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .mem         (mem_bus.master),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .bank_sel    (bank_sel),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Framebuffer model: one-cycle read latency
  always @(posedge clk_25) begin
    if (mem_bus.mem_rd)
      mem_bus.mem_data <= 8'h7F ^ mem_bus.mem_addr[7:0] ^ mem_bus.mem_addr[15:8]
                          ^ {mem_bus.mem_addr[16], 7'b0000000};
    else
      mem_bus.mem_data <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One pixel clock with the given counters; syncs derived from position.
  // Returns 1 time unit after the sampling edge.
  task automatic drive(input int h, input int v);
    hs       = h[9:0];
    vs       = v[9:0];
    hsync_in = !(h >= 657 && h <= 735);
    vsync_in = !(v >= 490 && v <= 491);
    @(posedge clk_25);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    swap_req = 1'b0;
    hs       = 10'd0;
    vs       = 10'd0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    mem_bus.mem_data = 8'h00;

    // Reset state, with hsync_in low and a frame-start position applied
    drive(700, 0);
    drive(0, 0);
    check("rst_swap_ack",  {31'd0, swap_ack},    32'd0);
    check("rst_bank_sel",  {31'd0, bank_sel},    32'd0);
    check("rst_frame_st",  {31'd0, frame_start}, 32'd0);
    check("rst_mem_rd",    {31'd0, mem_bus.mem_rd},   32'd0);
    check("rst_mem_addr",  {15'd0, mem_bus.mem_addr}, 32'd0);
    check("rst_rgb",       {8'd0, vga_r, vga_g, vga_b}, 32'h000000);
    check("rst_hsync",     {31'd0, vga_hsync}, 32'd1);
    check("rst_vsync",     {31'd0, vga_vsync}, 32'd1);
    rst = 1'b0;

    // Frame-start pulse
    drive(0, 0);
    check("frame_start_hi", {31'd0, frame_start}, 32'd1);
    drive(1, 0);
    check("frame_start_lo", {31'd0, frame_start}, 32'd0);

    // Top-left image pixel
    drive(192, 112);
    check("tl_addr", {15'd0, mem_bus.mem_addr}, 32'h00000);
    check("tl_rd",   {31'd0, mem_bus.mem_rd},   32'd1);
    drive(193, 112);
    drive(194, 112);
    check("tl_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'h7F7F7F);
    drive(195, 112);
    check("tl1_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h7E7E7E);

    // Bottom-right image pixel and first border pixel to its right
    drive(447, 367);
    check("br_addr", {15'd0, mem_bus.mem_addr}, 32'h0FFFF);
    check("br_rd",   {31'd0, mem_bus.mem_rd},   32'd1);
    drive(448, 367);
    check("bd_rd",   {31'd0, mem_bus.mem_rd},   32'd0);
    check("bd_hold", {15'd0, mem_bus.mem_addr}, 32'h0FFFF);
    drive(449, 367);
    check("br_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'h7F7F7F);
    drive(450, 367);
    check("bd_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'h000040);

    // Horizontal blanking: black RGB, hsync delayed 3 cycles
    drive(700, 100);
    drive(655, 100);
    drive(656, 100);
    check("blank_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h000000);
    drive(657, 100);
    drive(658, 100);
    check("hsync_still_hi", {31'd0, vga_hsync}, 32'd1);
    drive(659, 100);
    check("hsync_lo_3cyc",  {31'd0, vga_hsync}, 32'd0);

    // Swap request during active video: flip at hs=0,vs=480 only once
    swap_req = 1'b1;
    drive(300, 200);
    check("pend_bank", {31'd0, bank_sel}, 32'd0);
    check("pend_ack",  {31'd0, swap_ack}, 32'd0);
    drive(0, 480);
    check("flip_ack",  {31'd0, swap_ack}, 32'd1);
    check("flip_bank", {31'd0, bank_sel}, 32'd1);
    drive(1, 480);
    check("flip_ack_pulse", {31'd0, swap_ack}, 32'd0);
    drive(0, 0);
    check("frame2_start", {31'd0, frame_start}, 32'd1);
    drive(0, 480);
    check("held_no_ack",  {31'd0, swap_ack}, 32'd0);
    check("held_no_flip", {31'd0, bank_sel}, 32'd1);
    drive(192, 112);
    check("bank1_addr", {15'd0, mem_bus.mem_addr}, 32'h10000);
    drive(193, 112);
    drive(194, 112);
    check("bank1_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
    swap_req = 1'b0;
    drive(195, 112);

    // Reset while a request is pending discards it and restores bank 0
    swap_req = 1'b1;
    drive(300, 250);
    rst = 1'b1;
    drive(300, 250);
    check("mrst_bank", {31'd0, bank_sel}, 32'd0);
    check("mrst_ack",  {31'd0, swap_ack}, 32'd0);
    check("mrst_rd",   {31'd0, mem_bus.mem_rd},   32'd0);
    check("mrst_addr", {15'd0, mem_bus.mem_addr}, 32'd0);
    check("mrst_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'h000000);
    rst      = 1'b0;
    swap_req = 1'b0;
    drive(192, 112);
    check("post_rst_addr", {15'd0, mem_bus.mem_addr}, 32'h00000);
    drive(193, 112);
    drive(194, 112);
    check("post_rst_rgb",  {8'd0, vga_r, vga_g, vga_b}, 32'h7F7F7F);
    drive(0, 480);
    check("post_rst_no_ack",  {31'd0, swap_ack}, 32'd0);
    check("post_rst_no_flip", {31'd0, bank_sel}, 32'd0);

    // Request raised in vblank after the flip point waits a full frame
    swap_req = 1'b1;
    drive(5, 490);
    check("vb_no_ack", {31'd0, swap_ack}, 32'd0);
    drive(6, 490);
    drive(7, 490);
    check("vsync_lo_3cyc", {31'd0, vga_vsync}, 32'd0);
    drive(0, 524);
    drive(0, 0);
    drive(100, 300);
    check("vb_no_flip", {31'd0, bank_sel}, 32'd0);
    drive(0, 480);
    check("vb_flip_ack",  {31'd0, swap_ack}, 32'd1);
    check("vb_flip_bank", {31'd0, bank_sel}, 32'd1);
    swap_req = 1'b0;
    drive(1, 480);
    check("vb_ack_pulse", {31'd0, swap_ack}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
